// File: rtl/alu_issue_queue_pkg.sv
// Shared types and widths for the ALU issue queue.
package alu_issue_queue_pkg;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned PcW      = 48;
    localparam int unsigned AluTypeW = 11;

    // Op payload carried through the queue untouched; tags and operands live beside it.
    typedef struct packed {
        logic [XLEN-1:0]     imm;
        logic [PcW-1:0]      pc;
        logic [AluTypeW-1:0] alu_type;
        logic                is_word;
        logic                is_unsigned;
        logic                is_imm;
    } alu_iq_entry_t;

endpackage

// File: rtl/alu_issue_queue_wakeup.sv
// One operand's wakeup: tag compare against the writeback bus plus ready/data capture.
module iq_wakeup_cell #(
    parameter int unsigned PregWidth = 6,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 rdy_i,
    input  logic [PregWidth-1:0] prs_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 wb_valid_i,
    input  logic [PregWidth-1:0] wb_prd_i,
    input  logic [DataWidth-1:0] wb_data_i,
    output logic                 rdy_o,
    output logic [DataWidth-1:0] data_o
);

    logic hit;

    // Tag 0 is the hardwired zero register and never broadcasts.
    assign hit    = wb_valid_i & (wb_prd_i != '0) & ~rdy_i & (prs_i == wb_prd_i);
    assign rdy_o  = rdy_i | hit;
    assign data_o = hit ? wb_data_i : data_i;

endmodule

// File: rtl/alu_issue_queue.sv
// Collapsing age-ordered issue queue feeding the ALU; index 0 holds the oldest op.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PREG_WIDTH = 6,
    parameter int unsigned ROB_WIDTH  = 6
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PREG_WIDTH-1:0]        enq_prs1,
    input  logic [PREG_WIDTH-1:0]        enq_prs2,
    input  logic                         enq_src1_rdy,
    input  logic                         enq_src2_rdy,
    input  logic [XLEN-1:0]              enq_src1,
    input  logic [XLEN-1:0]              enq_src2,
    input  logic [PREG_WIDTH-1:0]        enq_prd,
    input  logic [ROB_WIDTH-1:0]         enq_robid,
    input  logic [XLEN-1:0]              enq_imm,
    input  logic [PcW-1:0]               enq_pc,
    input  logic [AluTypeW-1:0]          enq_alu_type,
    input  logic                         enq_is_word,
    input  logic                         enq_is_unsigned,
    input  logic                         enq_is_imm,
    input  logic                         wb_valid,
    input  logic [PREG_WIDTH-1:0]        wb_prd,
    input  logic [XLEN-1:0]              wb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [PREG_WIDTH-1:0]        issue_prd,
    output logic [ROB_WIDTH-1:0]         issue_robid,
    output logic [XLEN-1:0]              issue_src1,
    output logic [XLEN-1:0]              issue_src2,
    output logic [XLEN-1:0]              issue_imm,
    output logic [PcW-1:0]               issue_pc,
    output logic [AluTypeW-1:0]          issue_alu_type,
    output logic                         issue_is_word,
    output logic                         issue_is_unsigned,
    output logic                         issue_is_imm,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      rdy1_q, rdy1_d, rdy1_w;
    logic [DEPTH-1:0]      rdy2_q, rdy2_d, rdy2_w;
    logic [PREG_WIDTH-1:0] prs1_q [DEPTH];
    logic [PREG_WIDTH-1:0] prs1_d [DEPTH];
    logic [PREG_WIDTH-1:0] prs2_q [DEPTH];
    logic [PREG_WIDTH-1:0] prs2_d [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q  [DEPTH];
    logic [PREG_WIDTH-1:0] prd_d  [DEPTH];
    logic [ROB_WIDTH-1:0]  robid_q[DEPTH];
    logic [ROB_WIDTH-1:0]  robid_d[DEPTH];
    logic [XLEN-1:0]       src1_q [DEPTH];
    logic [XLEN-1:0]       src1_d [DEPTH];
    logic [XLEN-1:0]       src1_w [DEPTH];
    logic [XLEN-1:0]       src2_q [DEPTH];
    logic [XLEN-1:0]       src2_d [DEPTH];
    logic [XLEN-1:0]       src2_w [DEPTH];
    alu_iq_entry_t         op_q   [DEPTH];
    alu_iq_entry_t         op_d   [DEPTH];
    logic [CntW-1:0]       count_q, count_d;

    logic                  enq_rdy1_w, enq_rdy2_w;
    logic [XLEN-1:0]       enq_src1_w, enq_src2_w;
    alu_iq_entry_t         enq_op;
    alu_iq_entry_t         sel_op;

    logic                  found;
    logic [IdxW-1:0]       sel_idx;
    logic [IdxW-1:0]       wr_idx;
    logic [IdxW-1:0]       shift_idx;
    logic                  issue_fire;
    logic                  enq_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_wakeup_cell #(
            .PregWidth (PREG_WIDTH),
            .DataWidth (XLEN)
        ) u_src1 (
            .rdy_i      (rdy1_q[g]),
            .prs_i      (prs1_q[g]),
            .data_i     (src1_q[g]),
            .wb_valid_i (wb_valid),
            .wb_prd_i   (wb_prd),
            .wb_data_i  (wb_data),
            .rdy_o      (rdy1_w[g]),
            .data_o     (src1_w[g])
        );
        iq_wakeup_cell #(
            .PregWidth (PREG_WIDTH),
            .DataWidth (XLEN)
        ) u_src2 (
            .rdy_i      (rdy2_q[g]),
            .prs_i      (prs2_q[g]),
            .data_i     (src2_q[g]),
            .wb_valid_i (wb_valid),
            .wb_prd_i   (wb_prd),
            .wb_data_i  (wb_data),
            .rdy_o      (rdy2_w[g]),
            .data_o     (src2_w[g])
        );
    end

    // Same-cycle capture for the op being dispatched.
    iq_wakeup_cell #(
        .PregWidth (PREG_WIDTH),
        .DataWidth (XLEN)
    ) u_enq_src1 (
        .rdy_i      (enq_src1_rdy),
        .prs_i      (enq_prs1),
        .data_i     (enq_src1),
        .wb_valid_i (wb_valid),
        .wb_prd_i   (wb_prd),
        .wb_data_i  (wb_data),
        .rdy_o      (enq_rdy1_w),
        .data_o     (enq_src1_w)
    );

    iq_wakeup_cell #(
        .PregWidth (PREG_WIDTH),
        .DataWidth (XLEN)
    ) u_enq_src2 (
        .rdy_i      (enq_src2_rdy),
        .prs_i      (enq_prs2),
        .data_i     (enq_src2),
        .wb_valid_i (wb_valid),
        .wb_prd_i   (wb_prd),
        .wb_data_i  (wb_data),
        .rdy_o      (enq_rdy2_w),
        .data_o     (enq_src2_w)
    );

    assign enq_op.imm         = enq_imm;
    assign enq_op.pc          = enq_pc;
    assign enq_op.alu_type    = enq_alu_type;
    assign enq_op.is_word     = enq_is_word;
    assign enq_op.is_unsigned = enq_is_unsigned;
    assign enq_op.is_imm      = enq_is_imm;

    // Oldest-first select uses registered ready bits only, so wakeup never bypasses to issue.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                found   = 1'b1;
                sel_idx = IdxW'(i);
            end
        end
    end

    assign enq_ready  = (count_q < CntW'(DEPTH));
    assign issue_fire = found & ~flush & issue_ready;
    assign enq_fire   = enq_valid & enq_ready & ~flush;
    assign wr_idx     = IdxW'(count_q - CntW'(issue_fire));

    always_comb begin
        rdy1_d    = rdy1_q;
        rdy2_d    = rdy2_q;
        prs1_d    = prs1_q;
        prs2_d    = prs2_q;
        prd_d     = prd_q;
        robid_d   = robid_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        op_d      = op_q;
        shift_idx = '0;
        // Entries at or above the issued slot pull from their upper neighbour.
        for (int i = 0; i < DEPTH; i++) begin
            shift_idx = IdxW'(i);
            if (issue_fire && (IdxW'(i) >= sel_idx) && (i < DEPTH - 1)) begin
                shift_idx = IdxW'(i + 1);
            end
            rdy1_d[i]  = rdy1_w[shift_idx];
            rdy2_d[i]  = rdy2_w[shift_idx];
            src1_d[i]  = src1_w[shift_idx];
            src2_d[i]  = src2_w[shift_idx];
            prs1_d[i]  = prs1_q[shift_idx];
            prs2_d[i]  = prs2_q[shift_idx];
            prd_d[i]   = prd_q[shift_idx];
            robid_d[i] = robid_q[shift_idx];
            op_d[i]    = op_q[shift_idx];
        end
        if (enq_fire) begin
            rdy1_d[wr_idx]  = enq_rdy1_w;
            rdy2_d[wr_idx]  = enq_rdy2_w;
            src1_d[wr_idx]  = enq_src1_w;
            src2_d[wr_idx]  = enq_src2_w;
            prs1_d[wr_idx]  = enq_prs1;
            prs2_d[wr_idx]  = enq_prs2;
            prd_d[wr_idx]   = enq_prd;
            robid_d[wr_idx] = enq_robid;
            op_d[wr_idx]    = enq_op;
        end
    end

    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(enq_fire) - CntW'(issue_fire);
        end
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = (CntW'(i) < count_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            valid_q <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through valid/found.
    always_ff @(posedge clock) begin
        rdy1_q  <= rdy1_d;
        rdy2_q  <= rdy2_d;
        prs1_q  <= prs1_d;
        prs2_q  <= prs2_d;
        prd_q   <= prd_d;
        robid_q <= robid_d;
        src1_q  <= src1_d;
        src2_q  <= src2_d;
        op_q    <= op_d;
    end

    assign sel_op            = found ? op_q[sel_idx] : '0;
    assign issue_valid       = found & ~flush;
    assign issue_prd         = found ? prd_q[sel_idx] : '0;
    assign issue_robid       = found ? robid_q[sel_idx] : '0;
    assign issue_src1        = found ? src1_q[sel_idx] : '0;
    assign issue_src2        = found ? src2_q[sel_idx] : '0;
    assign issue_imm         = sel_op.imm;
    assign issue_pc          = sel_op.pc;
    assign issue_alu_type    = sel_op.alu_type;
    assign issue_is_word     = sel_op.is_word;
    assign issue_is_unsigned = sel_op.is_unsigned;
    assign issue_is_imm      = sel_op.is_imm;
    assign count             = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomised and directed bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 6;
    localparam int RW    = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [PW-1:0] enq_prs1 = '0, enq_prs2 = '0, enq_prd = '0;
    logic          enq_src1_rdy = 1'b0, enq_src2_rdy = 1'b0;
    logic [63:0]   enq_src1 = '0, enq_src2 = '0, enq_imm = '0;
    logic [RW-1:0] enq_robid = '0;
    logic [47:0]   enq_pc = '0;
    logic [10:0]   enq_alu_type = '0;
    logic          enq_is_word = 1'b0, enq_is_unsigned = 1'b0, enq_is_imm = 1'b0;
    logic          wb_valid = 1'b0;
    logic [PW-1:0] wb_prd = '0;
    logic [63:0]   wb_data = '0;
    logic          issue_valid;
    logic          issue_ready = 1'b0;
    logic [PW-1:0] issue_prd;
    logic [RW-1:0] issue_robid;
    logic [63:0]   issue_src1, issue_src2, issue_imm;
    logic [47:0]   issue_pc;
    logic [10:0]   issue_alu_type;
    logic          issue_is_word, issue_is_unsigned, issue_is_imm;
    logic [CW-1:0] count;

    always #5 clock = ~clock;

    alu_issue_queue #(
        .DEPTH      (DEPTH),
        .PREG_WIDTH (PW),
        .ROB_WIDTH  (RW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_prs1          (enq_prs1),
        .enq_prs2          (enq_prs2),
        .enq_src1_rdy      (enq_src1_rdy),
        .enq_src2_rdy      (enq_src2_rdy),
        .enq_src1          (enq_src1),
        .enq_src2          (enq_src2),
        .enq_prd           (enq_prd),
        .enq_robid         (enq_robid),
        .enq_imm           (enq_imm),
        .enq_pc            (enq_pc),
        .enq_alu_type      (enq_alu_type),
        .enq_is_word       (enq_is_word),
        .enq_is_unsigned   (enq_is_unsigned),
        .enq_is_imm        (enq_is_imm),
        .wb_valid          (wb_valid),
        .wb_prd            (wb_prd),
        .wb_data           (wb_data),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_prd         (issue_prd),
        .issue_robid       (issue_robid),
        .issue_src1        (issue_src1),
        .issue_src2        (issue_src2),
        .issue_imm         (issue_imm),
        .issue_pc          (issue_pc),
        .issue_alu_type    (issue_alu_type),
        .issue_is_word     (issue_is_word),
        .issue_is_unsigned (issue_is_unsigned),
        .issue_is_imm      (issue_is_imm),
        .count             (count)
    );

    typedef struct {
        logic [PW-1:0] prs1, prs2, prd;
        bit            rdy1, rdy2;
        logic [63:0]   src1, src2, imm;
        logic [RW-1:0] robid;
        logic [47:0]   pc;
        logic [10:0]   alu_type;
        logic [2:0]    flags;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_sel();
        foreach (q[i]) if (q[i].rdy1 && q[i].rdy2) return i;
        return -1;
    endfunction

    function automatic bit wake_hit(input bit rdy, input logic [PW-1:0] prs);
        return wb_valid && (wb_prd != '0) && !rdy && (prs == wb_prd);
    endfunction

    task automatic model_check();
        int k;
        k = model_sel();
        chk("count", 64'(count), 64'(q.size()));
        chk("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
        chk("issue_valid", 64'(issue_valid), 64'((k >= 0) && !flush));
        if (k >= 0 && !flush) begin
            chk("issue_robid", 64'(issue_robid), 64'(q[k].robid));
            chk("issue_prd", 64'(issue_prd), 64'(q[k].prd));
            chk("issue_src1", issue_src1, q[k].src1);
            chk("issue_src2", issue_src2, q[k].src2);
            chk("issue_imm", issue_imm, q[k].imm);
            chk("issue_pc", 64'(issue_pc), 64'(q[k].pc));
            chk("issue_alu_type", 64'(issue_alu_type), 64'(q[k].alu_type));
            chk("issue_flags", 64'({issue_is_word, issue_is_unsigned, issue_is_imm}),
                64'(q[k].flags));
        end else if (q.size() == 0) begin
            chk("idle_src1", issue_src1, 64'd0);
            chk("idle_robid", 64'(issue_robid), 64'd0);
        end
    endtask

    task automatic model_update();
        int   k;
        bit   do_enq;
        ent_t e;
        if (reset || flush) begin
            q.delete();
            return;
        end
        k = model_sel();
        do_enq = enq_valid && (q.size() < DEPTH);
        if (k >= 0 && issue_ready) q.delete(k);
        foreach (q[i]) begin
            if (wake_hit(q[i].rdy1, q[i].prs1)) begin q[i].rdy1 = 1'b1; q[i].src1 = wb_data; end
            if (wake_hit(q[i].rdy2, q[i].prs2)) begin q[i].rdy2 = 1'b1; q[i].src2 = wb_data; end
        end
        if (do_enq) begin
            e.prs1 = enq_prs1; e.prs2 = enq_prs2; e.prd = enq_prd;
            e.rdy1 = enq_src1_rdy; e.rdy2 = enq_src2_rdy;
            e.src1 = enq_src1; e.src2 = enq_src2; e.imm = enq_imm;
            e.robid = enq_robid; e.pc = enq_pc; e.alu_type = enq_alu_type;
            e.flags = {enq_is_word, enq_is_unsigned, enq_is_imm};
            if (wake_hit(e.rdy1, e.prs1)) begin e.rdy1 = 1'b1; e.src1 = wb_data; end
            if (wake_hit(e.rdy2, e.prs2)) begin e.rdy2 = 1'b1; e.src2 = wb_data; end
            q.push_back(e);
        end
    endtask

    // Inputs are driven at posedge+1; outputs compared at posedge+4.
    task automatic cyc();
        #3;
        if (!reset) model_check();
        model_update();
        @(posedge clock);
        #1;
        enq_valid = 1'b0;
        wb_valid  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drive_enq(input logic [PW-1:0] p1, input bit r1, input logic [63:0] s1,
                             input logic [PW-1:0] p2, input bit r2, input logic [63:0] s2,
                             input logic [RW-1:0] rob);
        enq_valid       = 1'b1;
        enq_prs1        = p1;
        enq_src1_rdy    = r1;
        enq_src1        = s1;
        enq_prs2        = p2;
        enq_src2_rdy    = r2;
        enq_src2        = s2;
        enq_robid       = rob;
        enq_prd         = PW'($urandom_range(1, 63));
        enq_imm         = {$urandom, $urandom};
        enq_pc          = {16'($urandom), $urandom};
        enq_alu_type    = 11'h1;
        enq_is_word     = 1'($urandom);
        enq_is_unsigned = 1'($urandom);
        enq_is_imm      = 1'($urandom);
    endtask

    task automatic wake(input logic [PW-1:0] tag, input logic [63:0] data);
        wb_valid = 1'b1;
        wb_prd   = tag;
        wb_data  = data;
    endtask

    initial begin
        @(posedge clock);
        #1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_issue_src1", issue_src1, 64'd0);

        // Ready op issues the cycle after dispatch.
        issue_ready = 1'b1;
        drive_enq(6'd3, 1'b1, 64'd5, 6'd4, 1'b1, 64'd7, 6'd1);
        cyc();
        chk("add_valid", 64'(issue_valid), 64'd1);
        chk("add_src1", issue_src1, 64'd5);
        chk("add_src2", issue_src2, 64'd7);
        cyc();
        chk("add_count", 64'(count), 64'd0);

        // Younger ready op overtakes an older waiting one; wakeup then frees the older one.
        drive_enq(6'd9, 1'b0, 64'd0, 6'd0, 1'b1, 64'd2, 6'd1);
        cyc();
        drive_enq(6'd1, 1'b1, 64'd8, 6'd2, 1'b1, 64'd9, 6'd2);
        cyc();
        chk("ab_first", 64'(issue_robid), 64'd2);
        cyc();
        wake(6'd9, 64'h1234);
        cyc();
        chk("ab_woken_valid", 64'(issue_valid), 64'd1);
        chk("ab_woken_robid", 64'(issue_robid), 64'd1);
        chk("ab_woken_src1", issue_src1, 64'h1234);
        cyc();

        // Fill, reject a fifth, wake the middle and check collapse order.
        for (int i = 0; i < 4; i++) begin
            drive_enq(PW'(20 + i), 1'b0, 64'd0, 6'd0, 1'b1, 64'd0, RW'(10 + i));
            cyc();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        drive_enq(6'd30, 1'b0, 64'd0, 6'd0, 1'b1, 64'd0, 6'd14);
        cyc();
        chk("reject_count", 64'(count), 64'd4);
        wake(6'd22, 64'h22);
        cyc();
        chk("mid_robid", 64'(issue_robid), 64'd12);
        cyc();
        issue_ready = 1'b0;
        wake(6'd23, 64'h23);
        cyc();
        wake(6'd21, 64'h21);
        cyc();
        chk("older_wins", 64'(issue_robid), 64'd11);
        issue_ready = 1'b1;
        cyc();
        chk("shifted_robid", 64'(issue_robid), 64'd13);
        cyc();
        chk("one_left", 64'(count), 64'd1);
        wake(6'd20, 64'h20);
        cyc();
        chk("last_robid", 64'(issue_robid), 64'd10);
        cyc();

        // Wakeup coincident with dispatch is captured.
        drive_enq(6'd1, 1'b1, 64'd3, 6'd12, 1'b0, 64'd0, 6'd5);
        wake(6'd12, 64'hAA);
        cyc();
        chk("bypass_valid", 64'(issue_valid), 64'd1);
        chk("bypass_src2", issue_src2, 64'hAA);
        cyc();

        // Stalled output holds the oldest, then drains in order.
        issue_ready = 1'b0;
        drive_enq(6'd1, 1'b1, 64'd1, 6'd2, 1'b1, 64'd2, 6'd30);
        cyc();
        drive_enq(6'd1, 1'b1, 64'd3, 6'd2, 1'b1, 64'd4, 6'd31);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("stall_robid", 64'(issue_robid), 64'd30);
            cyc();
        end
        issue_ready = 1'b1;
        chk("drain_first", 64'(issue_robid), 64'd30);
        cyc();
        chk("drain_second", 64'(issue_robid), 64'd31);
        cyc();

        // Flush beats enqueue and issue.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_enq(6'd1, 1'b1, 64'd1, 6'd2, 1'b1, 64'd2, RW'(40 + i));
            cyc();
        end
        flush = 1'b1;
        issue_ready = 1'b1;
        drive_enq(6'd1, 1'b1, 64'd1, 6'd2, 1'b1, 64'd2, 6'd43);
        #3;
        chk("flush_issue_valid", 64'(issue_valid), 64'd0);
        cyc();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_enq_ready", 64'(enq_ready), 64'd1);

        // Random traffic against the model.
        repeat (2000) begin
            drive_enq(PW'($urandom_range(1, 7)), 1'($urandom), {$urandom, $urandom},
                      PW'($urandom_range(1, 7)), 1'($urandom), {$urandom, $urandom},
                      RW'($urandom));
            enq_alu_type = 11'(1 << $urandom_range(0, 10));
            enq_valid    = ($urandom_range(0, 3) != 0);
            wb_valid     = ($urandom_range(0, 2) != 0);
            wb_prd       = PW'($urandom_range(0, 7));
            wb_data      = {$urandom, $urandom};
            issue_ready  = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 60) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Collapsing, age-ordered issue queue that holds renamed integer ALU micro-ops until both source operands are available, then hands the oldest ready op to the `alu` execute stage. Sits between rename/dispatch and the ALU functional unit. It captures operand values from the writeback broadcast, so the ALU receives fully resolved `src1`/`src2`. Flush empties it in one cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of entries, ≥2.
- `PREG_WIDTH`, 6: physical register tag width.
- `ROB_WIDTH`, 6: ROB index width.

Ports:
- `clock`, in, 1: single clock, all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: discard all entries.
- `enq_valid`, in, 1: dispatch offers an op.
- `enq_ready`, out, 1: queue accepts (`count < DEPTH`).
- `enq_prs1`, `enq_prs2`, in, PREG_WIDTH: source tags.
- `enq_src1_rdy`, `enq_src2_rdy`, in, 1: operand already valid.
- `enq_src1`, `enq_src2`, in, 64: operand values, meaningful only when the matching rdy bit is set.
- `enq_prd`, in, PREG_WIDTH: destination tag.
- `enq_robid`, in, ROB_WIDTH.
- `enq_imm`, in, 64.
- `enq_pc`, in, 48.
- `enq_alu_type`, in, 11: one-hot ALU op.
- `enq_is_word`, `enq_is_unsigned`, `enq_is_imm`, in, 1.
- `wb_valid`, in, 1: writeback broadcast.
- `wb_prd`, in, PREG_WIDTH.
- `wb_data`, in, 64.
- `issue_valid`, out, 1: an entry is ready to issue.
- `issue_ready`, in, 1: ALU stage accepts.
- `issue_*`, out: same field set as `enq_*`, minus the rdy bits and prs tags. Sources go out as `issue_src1`/`issue_src2`.
- `count`, out, $clog2(DEPTH+1): occupancy.

## Operation
- Entry storage: `valid`, `rdy1`, `rdy2`, tags, `src1`, `src2`, and the op fields. Index 0 is the oldest; valid entries are always contiguous from index 0.
- Enqueue: fires when `enq_valid & enq_ready & !flush`. The op is written at index `count - (issue fire ? 1 : 0)`.
- `enq_ready` depends on `count` only. It does not account for a same-cycle issue, so a full queue rejects even while issuing.
- Wakeup, resident entries: when `wb_valid` and `wb_prd != 0`, every valid entry with `!rdyN & prsN == wb_prd` sets `rdyN` and latches `wb_data` into `srcN`.
- Wakeup, enqueuing op: the same match is applied to the enqueuing op in the same cycle (enqueue bypass). A set `enq_srcN_rdy` is never overwritten.
- Select: the lowest index with `valid & rdy1 & rdy2`.
  - `issue_valid = found & !flush`.
  - `issue_*` are driven combinationally from the selected entry.
- Issue fire: `issue_valid & issue_ready`. The selected entry is removed, and entries above it shift down by one, keeping age order.
- Flush: highest priority. All `valid` bits clear, and enqueue and issue fire are suppressed that cycle.
- Reset: same effect as flush.
- `count` equals the number of valid entries. On the same cycle it goes +1 for enqueue only, −1 for issue only, and is unchanged when both fire.

## Timing
- Reset values: all `valid` = 0, `count` = 0, `issue_valid` = 0, `enq_ready` = 1, `issue_*` = 0 (data fields are gated with `valid`).
- Enqueue with both operands ready at edge N: the entry is `issue_valid` in cycle N+1.
- Minimum latency: dispatch to issue is 1 cycle.
- Wakeup seen at edge N: the entry can issue in cycle N+1. Wakeup never makes `issue_valid` rise in the same cycle as the broadcast (no same-cycle bypass to select).
- Handshake: `issue_valid` does not depend on `issue_ready`.
- If `issue_ready` = 0, the selected entry stays. A younger entry may never overtake an older ready one.
- If an older entry becomes ready while a younger one is stalled at the output, the next cycle selects the older one.
- Back-to-back issue at 1 op/cycle is sustained while ready entries exist.
- Flush in cycle N: `issue_valid` = 0 in N. The queue is empty and `enq_ready` = 1 in N+1.

## Structure
- The shared `defines.sv` provides `SRC_RANGE`, `PC_RANGE`, `ALU_TYPE_RANGE`, and the new `PREG_RANGE`/`ROB_RANGE` macros.
- Add a packed entry struct `alu_iq_entry_t` to the backend package.
- One natural sub-module, `iq_wakeup_cell`: a single operand's tag-compare plus ready/data capture. It is instantiated 2×DEPTH, plus 2 for the enqueue bypass.

## Test plan
- Reset, then enqueue `alu_type = 1` (ADD), rdy1 = rdy2 = 1, src1 = 5, src2 = 7, `issue_ready` = 1 → `issue_valid` in the next cycle with `issue_src1` = 5 and `issue_src2` = 7; then `count` = 0.
- Enqueue A (prs1 = 9, not ready), then B (ready) → B issues first. Then `wb_valid`, `wb_prd` = 9, `wb_data` = 0x1234 → A issues one cycle later with `issue_src1` = 0x1234.
- Fill 4 entries none ready, with `issue_ready` = 1 → `enq_ready` = 0 and `count` = 4. A 5th `enq_valid` is rejected. Wake entry 2 → it issues and entries 3→2 shift, with order preserved.
- Enqueue prs2 = 12 not ready, in the same cycle as `wb_prd` = 12, `wb_data` = 0xAA → the entry issues next cycle with `issue_src2` = 0xAA.
- Two ready entries with `issue_ready` = 0 for 3 cycles → `issue_robid` stays equal to the oldest robid. Raise `issue_ready` → two consecutive issues in age order.
- 3 entries valid, assert `flush` together with `enq_valid` and `issue_ready` → `issue_valid` = 0 that cycle, nothing enqueued, `count` = 0 next cycle.
